// File: rtl/scarv_cop_rng_pool.sv
// Entropy pool feeding the coprocessor RNG seed path: repetition-count health test,
// 32-bit word packing and a valid/ready seed port. Define SCARV_COP_RNG_POOL_VN_DEBIAS_EN for Von Neumann debiasing.
module scarv_cop_rng_pool #(
    parameter int unsigned RCT_CUTOFF       = 32,
    parameter logic [31:0] POOL_RESET_VALUE = 32'b0
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        es_valid,
    input  logic        es_bit,
    input  logic        pool_clear,
    input  logic        seed_ready,
    output logic        seed_valid,
    output logic [31:0] seed_data,
    output logic        health_fail,
    output logic [5:0]  fill_level
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        FAIL = 2'd2
    } state_t;

    localparam logic [7:0] RCT_CUT = 8'(RCT_CUTOFF);

    state_t      state_q, state_d;
    logic [31:0] pool_q, pool_d;
    logic [5:0]  fill_q, fill_d;
    logic [7:0]  rct_q, rct_d;
    logic        last_q, last_d;
    logic [7:0]  rct_next;
    logic        raw_seen;

`ifdef SCARV_COP_RNG_POOL_VN_DEBIAS_EN
    logic        pair_q, pair_d;
    logic        phase_q, phase_d;
`endif

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= FILL;
            pool_q  <= POOL_RESET_VALUE;
            fill_q  <= 6'd0;
            rct_q   <= 8'd0;
            last_q  <= 1'b0;
`ifdef SCARV_COP_RNG_POOL_VN_DEBIAS_EN
            pair_q  <= 1'b0;
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pool_q  <= pool_d;
            fill_q  <= fill_d;
            rct_q   <= rct_d;
            last_q  <= last_d;
`ifdef SCARV_COP_RNG_POOL_VN_DEBIAS_EN
            pair_q  <= pair_d;
            phase_q <= phase_d;
`endif
        end
    end

    // rct_q == 0 marks "no previous bit" after reset or clear.
    always_comb begin
        raw_seen = es_valid && (state_q != FAIL);
        if ((rct_q == 8'd0) || (es_bit != last_q)) begin
            rct_next = 8'd1;
        end else if (rct_q >= RCT_CUT) begin
            rct_next = RCT_CUT;
        end else begin
            rct_next = rct_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        pool_d  = pool_q;
        fill_d  = fill_q;
        rct_d   = rct_q;
        last_d  = last_q;
`ifdef SCARV_COP_RNG_POOL_VN_DEBIAS_EN
        pair_d  = pair_q;
        phase_d = phase_q;
`endif

        if (raw_seen) begin
            rct_d  = rct_next;
            last_d = es_bit;
        end

        if (raw_seen && (rct_next == RCT_CUT)) begin
            state_d = FAIL;
            pool_d  = POOL_RESET_VALUE;
            fill_d  = 6'd0;
`ifdef SCARV_COP_RNG_POOL_VN_DEBIAS_EN
            phase_d = 1'b0;
`endif
        end else if (pool_clear) begin
            state_d = FILL;
            pool_d  = POOL_RESET_VALUE;
            fill_d  = 6'd0;
            rct_d   = 8'd0;
            last_d  = 1'b0;
`ifdef SCARV_COP_RNG_POOL_VN_DEBIAS_EN
            phase_d = 1'b0;
`endif
        end else if ((state_q == FULL) && seed_ready) begin
            state_d = FILL;
            pool_d  = POOL_RESET_VALUE;
            fill_d  = 6'd0;
`ifdef SCARV_COP_RNG_POOL_VN_DEBIAS_EN
            phase_d = 1'b0;
`endif
        end else if ((state_q == FILL) && es_valid) begin
`ifdef SCARV_COP_RNG_POOL_VN_DEBIAS_EN
            // Pair 01 yields 0 and 10 yields 1, i.e. the first bit of an unequal pair.
            if (!phase_q) begin
                pair_d  = es_bit;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (pair_q != es_bit) begin
                    pool_d = {pool_q[30:0], pair_q};
                    fill_d = fill_q + 6'd1;
                    if (fill_q == 6'd31) begin
                        state_d = FULL;
                    end
                end
            end
`else
            pool_d = {pool_q[30:0], es_bit};
            fill_d = fill_q + 6'd1;
            if (fill_q == 6'd31) begin
                state_d = FULL;
            end
`endif
        end
    end

    assign seed_data   = pool_q;
    assign seed_valid  = (state_q == FULL);
    assign health_fail = (state_q == FAIL);
    assign fill_level  = fill_q;

endmodule

// File: doc/scarv_cop_rng_pool.md
Name: scarv_cop_rng_pool

Overview:
- Entropy accumulation pool directly upstream of the coprocessor RNG block.
- Collects raw bits from a physical entropy source and runs a continuous repetition-count health test on them.
- Packs accepted bits into 32-bit seed words and offers each word on a valid/ready port; that port feeds the RNG's seed path (rs1 value for RSEED, driven by software or a seeding sequencer).
- Health failure is sticky and blocks all seed output until cleared.

Parameters:
- RCT_CUTOFF, 32: number of consecutive identical raw bits that trips the health test. Legal range 2..255.
- POOL_RESET_VALUE, 32'b0: value loaded into the pool register on reset, clear, failure and after each handshake.

Ports:
- g_clk  input  1  global clock
- g_resetn  input  1  reset, synchronous, active-low; clock g_clk
- es_valid  input  1  raw entropy bit present this cycle
- es_bit  input  1  raw entropy bit
- pool_clear  input  1  single-cycle pulse: flush pool, reset health state, leave FAIL
- seed_ready  input  1  consumer accepts seed_data this cycle
- seed_valid  output  1  seed_data holds a complete 32-bit word
- seed_data  output  32  seed word; held stable while seed_valid=1
- health_fail  output  1  sticky repetition-count failure flag
- fill_level  output  6  number of bits in pool, 0..32

Behaviour:
- States: FILL, FULL, FAIL.
- Reset values: state=FILL, pool=POOL_RESET_VALUE, fill_level=0, seed_valid=0, seed_data=POOL_RESET_VALUE, health_fail=0, rct_cnt=0.
- seed_data always drives the pool register. seed_valid=(state==FULL). health_fail=(state==FAIL).

FILL:
- On es_valid, a bit is accepted: pool <= {pool[30:0], bit}, fill_level+1.
- When the accepted bit makes fill_level=32, go to FULL next cycle. seed_valid rises the cycle after the 32nd accepted bit.

FULL:
- Accepts no bits into the pool; fill_level stays 32.
- seed_valid && seed_ready moves to FILL next cycle, with pool=POOL_RESET_VALUE and fill_level=0. A bit presented in the handshake cycle is not shifted into the pool.

Health test:
- Runs on every raw es_valid bit in FILL and FULL, before any debiasing.
- State held: last_bit, rct_cnt (8 bits, saturating at RCT_CUTOFF).
- First bit after reset or clear: rct_cnt=1.
- Bit equal to last_bit: rct_cnt+1. Different bit: rct_cnt=1.
- If the update makes rct_cnt==RCT_CUTOFF, go to FAIL next cycle.
- The tripping bit is not shifted into the pool.

FAIL:
- pool=POOL_RESET_VALUE, fill_level=0, seed_valid=0; es bits ignored.
- Left only via pool_clear or reset.

Precedence (highest first): reset > health failure > pool_clear > handshake > bit accept.
- Failure in the same cycle as seed_ready in FULL: no transfer, enter FAIL.
- pool_clear in any state: next cycle FILL, pool=POOL_RESET_VALUE, fill_level=0, rct_cnt=0. A bit in the clear cycle is ignored.

Reset mid-word discards partial contents; no seed is emitted.

Optional Feature:
Macro: SCARV_COP_RNG_POOL_VN_DEBIAS_EN

Defined (Von Neumann debiasing between health test and pool):
- Raw accepted bits are paired using a 1-bit pair register plus a phase flag.
- Pair 01 -> pool bit 0; pair 10 -> pool bit 1; pairs 00 and 11 are discarded.
- A pool bit is produced on the second bit of a pair only.
- Phase resets on reset, clear, failure and handshake.
- Health test is unchanged and still sees every raw bit.

Undefined: every raw accepted bit enters the pool directly; no pair logic is synthesised.

Test Plan:
- Fill, debias off: 32 bits alternating 1,0 starting at 1, es_valid every cycle -> seed_valid=1 one cycle after the 32nd bit, seed_data=0xAAAAAAAA, fill_level=32.
- Backpressure: hold seed_ready=0 for 10 cycles with es_valid=1 -> seed_data stays 0xAAAAAAAA. Then seed_ready=1 -> next cycle seed_valid=0, fill_level=0, pool=0.
- Health trip: with RCT_CUTOFF=32, feed 32 consecutive 1s -> health_fail=1 the cycle after the 32nd; seed_valid never rises; es bits are ignored afterwards.
- Clear: health_fail=1, pulse pool_clear -> next cycle health_fail=0, fill_level=0. Then 31 ones plus a zero -> no failure.
- Simultaneous: FULL with seed_ready=1, and the same cycle's es_bit completes a 32-run -> no handshake, FAIL next cycle.
- Debias on: raw stream 01,10,11,00 repeated -> pool gains bits 0,1 per repeat; 16 repeats -> seed_data=0x55555555.
